fetch_branch_unit: RTL
======================

# fetch_branch_unit

Instruction-fetch stage plus branch resolver for the 5-stage pipeline. Holds the PC and drives the instruction-memory address. Registers the fetched word into the IF/ID latch. Consumes the decode stage's branch controls (`is_branch_or_jump`, `branch_type`, immediate, register operands) to decide branch/jump direction and redirect fetch, squashing the wrong-path instruction. Sits between instruction memory and the decode stage, closing the branch loop back from ID.

## Interface
Parameters:
- `RESET_PC`, 32'h0: PC value loaded on reset.
- `PC_STEP`, 4: byte increment per sequential fetch.

Ports (reset is asynchronous, active-high):
- `clk`  in  1  pipeline clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `freeze`  in  1  hazard stall from the hazard unit; holds PC and IF/ID.
- `imem_addr`  out  32  byte address to instruction memory; equals the current PC.
- `imem_data`  in  32  instruction word; combinational read of `imem_addr`, valid in the same cycle.
- `id_is_branch_or_jump`  in  1  decode: the instruction in ID is BEZ, BNE or JMP.
- `id_branch_type`  in  2  decode: 0 = BEZ, 1 = BNE, 2 = JMP, 3 = reserved.
- `id_val1`, `id_val2`  in  32 each  register-file operands of the ID instruction.
- `id_imm`  in  16  immediate field of the ID instruction (word offset).
- `if_id_pc`  out  32  IF/ID latch: PC+`PC_STEP` of the latched instruction.
- `if_id_instr`  out  32  IF/ID latch: instruction word; 32'h0 (NOP) when squashed.
- `branch_taken`  out  1  combinational: the redirect occurs at the next edge.
- `fetch_count`  out  32  count of instructions latched into IF/ID (excluding squashes).

## Operation
- Reset values: PC = `RESET_PC`, `if_id_pc` = 0, `if_id_instr` = 0, `fetch_count` = 0. Reset forces `branch_taken` = 0 through the NOP in IF/ID.
- Branch decision, combinational:
  - BEZ is taken iff `id_val1` == 0.
  - BNE is taken iff `id_val1` != `id_val2`.
  - JMP is always taken.
  - Type 3 is never taken.
  - `branch_taken` = `id_is_branch_or_jump` & condition & ~`freeze`.
- Target = `if_id_pc` + (sign_extend32(`id_imm`) << 2). All arithmetic is modulo 2^32; the PC wraps silently.
- Each edge, in priority order:
  - `freeze`=1: PC, IF/ID and `fetch_count` hold. Freeze dominates a simultaneous branch, because the ID operands are not yet valid.
  - `branch_taken`=1: PC <= target; `if_id_instr` <= 0; `if_id_pc` <= 0; `fetch_count` holds. This squashes the fall-through word fetched this cycle.
  - Otherwise: PC <= PC+`PC_STEP`; `if_id_instr` <= `imem_data`; `if_id_pc` <= PC+`PC_STEP`; `fetch_count` += 1, wrapping at 2^32.
- A squashed NOP in ID never branches, so back-to-back redirects are impossible. Two branches in consecutive program slots: the second is squashed if the first is taken.
- `rst` asserted mid-operation immediately clears all state, including a pending branch or freeze. Fetch restarts at `RESET_PC` on the first edge after release.

## Timing
- Fetch latency: the word at PC appears on `if_id_instr` one edge later.
- Taken-branch penalty: exactly one bubble. The branch is in ID in cycle N. The target fetch occurs in cycle N+1. The target instruction is in ID in cycle N+2.
- The freeze-release cycle behaves as a normal cycle. A branch held in ID during freeze resolves on the first unfrozen cycle.
- The critical path is `if_id_pc` + offset through the target mux to the PC D-input. No added register stages.

## Structure
- Shared package `pipeline_pkg` holds:
  - `BR_TYPE_BEZ`/`BR_TYPE_BNE`/`BR_TYPE_JMP`.
  - `NOP_INSTR` = 32'h0.
  - The opcode constants already used by decode.
- One sub-module: `branch_resolver`. It is combinational: `id_branch_type`, operands, `id_is_branch_or_jump` -> condition. It is reused by the verification model.
- PC register, IF/ID latch and counter live in `fetch_branch_unit`.

## Test plan
- Reset with `RESET_PC`=32'h100 -> `imem_addr`=32'h100; after 3 unfrozen edges, `imem_addr`=32'h10C, `if_id_pc`=32'h10C, `fetch_count`=3.
- Stimulus: BEZ in ID with `if_id_pc`=32'h20, `id_imm`=16'hFFFE, `id_val1`=0.
  - Response: `branch_taken`=1; next PC = 32'h18; `if_id_instr`=0; `fetch_count` unchanged.
- BNE with `id_val1`=`id_val2`=7 -> not taken; sequential fetch continues. Repeat with `id_val2`=8 -> taken.
- JMP asserted together with `freeze`=1 for 2 cycles -> PC/IF/ID hold, `branch_taken`=0; on freeze release, redirect occurs with 1 bubble.
- PC=32'hFFFF_FFFC, no branch -> next PC = 32'h0. Branch type 3 with `id_is_branch_or_jump`=1 -> never taken.
- `rst` pulsed asynchronously mid-cycle while a taken branch is pending -> outputs clear immediately; fetch resumes at `RESET_PC`.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: branch encodings, opcodes used by decode,
// IF/ID payload and the branch-target helper.
package pipeline_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned IMM_W     = 16;
  localparam int unsigned BR_TYPE_W = 2;
  localparam int unsigned OPCODE_W  = 6;

  localparam logic [BR_TYPE_W-1:0] BR_TYPE_BEZ  = 2'd0;
  localparam logic [BR_TYPE_W-1:0] BR_TYPE_BNE  = 2'd1;
  localparam logic [BR_TYPE_W-1:0] BR_TYPE_JMP  = 2'd2;
  localparam logic [BR_TYPE_W-1:0] BR_TYPE_RSVD = 2'd3;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0;

  // Opcode field values shared with the decode stage
  localparam logic [OPCODE_W-1:0] OP_NOP = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_ADD = 6'h01;
  localparam logic [OPCODE_W-1:0] OP_SUB = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_AND = 6'h03;
  localparam logic [OPCODE_W-1:0] OP_OR  = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_LD  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_ST  = 6'h09;
  localparam logic [OPCODE_W-1:0] OP_BEZ = 6'h10;
  localparam logic [OPCODE_W-1:0] OP_BNE = 6'h11;
  localparam logic [OPCODE_W-1:0] OP_JMP = 6'h12;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_id_t;

  // Word-offset immediate, sign-extended and scaled to bytes, added modulo 2^32
  function automatic logic [XLEN-1:0] branch_target(input logic [XLEN-1:0] base,
                                                    input logic [IMM_W-1:0] imm);
    logic [XLEN-1:0] offset;
    offset = {{(XLEN-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
    return XLEN'(base + offset);
  endfunction

endpackage

// File: rtl/branch_resolver.sv
// Combinational branch/jump condition for the instruction sitting in ID.
module branch_resolver
  import pipeline_pkg::*;
(
  input  logic                 is_branch_or_jump,
  input  logic [BR_TYPE_W-1:0] branch_type,
  input  logic [XLEN-1:0]      val1,
  input  logic [XLEN-1:0]      val2,
  output logic                 taken_c
);

  logic cond_c;

  always_comb begin
    cond_c = 1'b0;
    case (branch_type)
      BR_TYPE_BEZ: cond_c = (val1 == '0);
      BR_TYPE_BNE: cond_c = (val1 != val2);
      BR_TYPE_JMP: cond_c = 1'b1;
      default:     cond_c = 1'b0;
    endcase
    taken_c = is_branch_or_jump & cond_c;
  end

endmodule

// File: rtl/fetch_branch_unit.sv
// Fetch stage: PC register, IF/ID latch and fetch counter, with the
// branch redirect resolved from the instruction currently in ID.
module fetch_branch_unit
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 freeze,
  output logic [XLEN-1:0]      imem_addr,
  input  logic [XLEN-1:0]      imem_data,
  input  logic                 id_is_branch_or_jump,
  input  logic [BR_TYPE_W-1:0] id_branch_type,
  input  logic [XLEN-1:0]      id_val1,
  input  logic [XLEN-1:0]      id_val2,
  input  logic [IMM_W-1:0]     id_imm,
  output logic [XLEN-1:0]      if_id_pc,
  output logic [XLEN-1:0]      if_id_instr,
  output logic                 branch_taken,
  output logic [XLEN-1:0]      fetch_count
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] seq_pc_c;
  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] fetch_count_q, fetch_count_d;
  if_id_t          if_id_q, if_id_d;
  logic            resolve_c;

  branch_resolver u_branch_resolver (
    .is_branch_or_jump (id_is_branch_or_jump),
    .branch_type       (id_branch_type),
    .val1              (id_val1),
    .val2              (id_val2),
    .taken_c           (resolve_c)
  );

  // Freeze wins over a branch: ID operands are not valid while stalled
  assign branch_taken = resolve_c & ~freeze & ~rst;
  assign seq_pc_c     = XLEN'(pc_q + XLEN'(PC_STEP));
  assign target_c     = branch_target(if_id_q.pc, id_imm);

  always_comb begin
    pc_d          = pc_q;
    if_id_d       = if_id_q;
    fetch_count_d = fetch_count_q;
    if (!freeze) begin
      if (branch_taken) begin
        pc_d          = target_c;
        if_id_d.pc    = '0;
        if_id_d.instr = NOP_INSTR;
      end else begin
        pc_d          = seq_pc_c;
        if_id_d.pc    = seq_pc_c;
        if_id_d.instr = imem_data;
        fetch_count_d = XLEN'(fetch_count_q + XLEN'(1));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      if_id_q       <= '0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      if_id_q       <= if_id_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_pc    = if_id_q.pc;
  assign if_id_instr = if_id_q.instr;
  assign fetch_count = fetch_count_q;

endmodule
